irrigation_cycle_controller: RTL
================================

# irrigation_cycle_controller

Sequencer for one tank cycle of the irrigation rig: fill, irrigate (pump out), and a mandatory rinse whenever pesticide entered the tank. It generates the 2-bit `state` bus that the pesticide verification logic decodes: 01 is the only window in which dosing is permitted, and 10 is the cleaning state that clears its latch. It consumes that logic's pesticide-present flag (`alert_on`) to decide whether a clean is required.

## Interface
Parameters:
- FILL_TIMEOUT, 64: max cycles in FILL waiting for `level_full` before fault.
- CLEAN_CYCLES, 8: exact number of cycles spent in CLEAN.
- TIMER_W, 8: timer width; must hold max(FILL_TIMEOUT, CLEAN_CYCLES).

Ports:
- clk  in  1  system clock; one clock for the whole block.
- init  in  1  reset, synchronous, active-high.
- start_btn  in  1  raw operator start button (not debounced).
- level_full  in  1  tank-full sensor, already synchronous to clk.
- level_empty  in  1  tank-empty sensor, already synchronous to clk.
- pesticide_on  in  1  pesticide-present flag from verification block (`alert_on`).
- state  out  2  cycle state: 00 IDLE, 01 FILL, 11 IRRIGATE, 10 CLEAN.
- valve_in  out  1  inlet valve open.
- valve_out  out  1  drain valve open.
- pump  out  1  irrigation pump on.
- fault  out  1  sticky fault: fill timeout or contradictory sensors.
- cycles_done  out  8  completed irrigation cycles, wraps.

## Operation
- Reset (`init`=1 at an edge): state=00, valve_in=0, valve_out=0, pump=0, fault=0, cycles_done=0, pest_seen=0, timer=0. `init` overrides every other input.
- Start request = single-cycle pulse from debounced `start_btn`. Accepted only in IDLE; ignored elsewhere (no queuing).
- IDLE (00): all actuators off. Start pulse -> FILL. Fault is cleared on the accepting edge.
- FILL (01): valve_in=1. Timer counts cycles in state.
  - level_full=1 and level_empty=0 -> IRRIGATE.
  - level_full=1 and level_empty=1 -> IDLE, fault=1 (sensor contradiction).
  - Otherwise, timer reaches FILL_TIMEOUT-1 -> IDLE, fault=1. level_full on the same edge as the timeout takes precedence.
- IRRIGATE (11): pump=1. On level_empty=1: cycles_done+1 (mod 256), then CLEAN if pest_seen=1 or pesticide_on=1 on that edge, else IDLE.
- CLEAN (10): valve_in=1, valve_out=1. Stays exactly CLEAN_CYCLES cycles, then IDLE. pest_seen clears on exit.
- pest_seen: set at any edge where pesticide_on=1 while state is FILL or IRRIGATE. It holds through IRRIGATE even if the flag drops, and is not set in IDLE or CLEAN.
- Actuator outputs are a pure decode of the state register, so there is no combinational path from inputs to outputs.

## Timing
- Start edge to state=01: 1 clk after the debouncer pulse (plus debouncer latency on the raw button).
- Sensor to state change: sensor sampled at edge N, new state visible after edge N.
- FILL lasts at most FILL_TIMEOUT cycles. CLEAN lasts exactly CLEAN_CYCLES cycles. Timer reloads to 0 on every state entry.
- cycles_done updates on the same edge that leaves IRRIGATE. 255 -> 0 wrap with no flag.
- `init` mid-cycle (any state): next edge gives IDLE with all outputs at reset values. An interrupted clean is not resumed.
- fault stays set through IDLE until `init` or an accepted start.

## Structure
- Shared package: state encodings ST_IDLE=2'b00, ST_FILL=2'b01, ST_IRRIG=2'b11, ST_CLEAN=2'b10. The verification block decodes these same values.
- Sub-module: the existing `debouncer` on start_btn. Everything else is one FSM, one timer and one counter in this module.

## Test plan
- Start pulse in IDLE, level_full at cycle 5, level_empty 10 cycles later, pesticide_on=0 -> state 00->01->11->00, cycles_done=1, CLEAN never entered.
- Same sequence with pesticide_on=1 for 1 cycle during FILL, then 0 -> IRRIGATE exits to CLEAN. valve_in=valve_out=1 for exactly 8 cycles, then IDLE.
- FILL with level_full never asserted -> IDLE after 64 cycles, fault=1. A new start clears fault and re-enters FILL.
- level_full=level_empty=1 in FILL -> IDLE, fault=1. Start pulses during IRRIGATE/CLEAN are ignored with no state change.
- `init` asserted at cycle 3 of CLEAN -> next edge state=00, all actuators 0, cycles_done=0.
- Preload 255 completed cycles, run one more cycle -> cycles_done wraps to 0.

Source files
------------

// File: rtl/irrigation_cycle_controller_pkg.sv
// Shared definitions for the irrigation tank-cycle sequencer.
// The state encodings are decoded directly by the pesticide verification
// block: 01 is the only dosing window and 10 clears its latch, so the
// values are fixed and must not be re-encoded.
package irrigation_cycle_controller_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_FILL  = 2'b01,
      ST_IRRIG = 2'b11,
      ST_CLEAN = 2'b10
   } cycle_state_t;

   localparam int CYCLES_W = 8;

   typedef struct packed {
      logic valve_in;
      logic valve_out;
      logic pump;
   } actuator_t;

   // Actuators are a pure function of the cycle state.
   function automatic actuator_t actuator_decode(input cycle_state_t st);
      actuator_t a;
      a = '0;
      case (st)
         ST_FILL:  a.valve_in = 1'b1;
         ST_IRRIG: a.pump     = 1'b1;
         ST_CLEAN: begin
            a.valve_in  = 1'b1;
            a.valve_out = 1'b1;
         end
         default:  a = '0;
      endcase
      return a;
   endfunction

endpackage

// File: rtl/irrigation_cycle_controller_debouncer.sv
// Start-button debouncer.
// Synchronises the raw button, accepts a new level only after it has been
// seen stable for STABLE_CYCLES consecutive samples, and emits a single-cycle
// pulse when the accepted level rises. Releases produce no pulse.
// A clean press first sampled at edge 1 yields the pulse in the cycle after
// edge STABLE_CYCLES+2.
// Ports:
//   clk   in  system clock
//   init  in  synchronous active-high reset
//   btn   in  raw asynchronous button
//   pulse out one-cycle start request
module debouncer #(
   parameter int STABLE_CYCLES = 4
) (
   input  logic clk,
   input  logic init,
   input  logic btn,
   output logic pulse
);

   localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;

   logic             sync_p0;
   logic             sync_p1;
   logic             stable_q;
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (init) begin
         sync_p0  <= 1'b0;
         sync_p1  <= 1'b0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
         pulse    <= 1'b0;
      end else begin
         // stage p0 -> p1: two-flop synchroniser
         sync_p0 <= btn;
         sync_p1 <= sync_p0;
         // stage p1 -> stable: any disagreement must persist to be accepted
         pulse   <= 1'b0;
         if (sync_p1 == stable_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
            stable_q <= sync_p1;
            cnt_q    <= '0;
            pulse    <= sync_p1;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/irrigation_cycle_controller.sv
// Tank-cycle sequencer: fill, irrigate, and a mandatory rinse whenever
// pesticide entered the tank during the cycle.
// Ports:
//   clk          in  system clock
//   init         in  synchronous active-high reset, overrides all inputs
//   start_btn    in  raw operator start button
//   level_full   in  tank-full sensor (synchronous)
//   level_empty  in  tank-empty sensor (synchronous)
//   pesticide_on in  pesticide-present flag from the verification block
//   state        out cycle state 00 IDLE, 01 FILL, 11 IRRIGATE, 10 CLEAN
//   valve_in     out inlet valve open
//   valve_out    out drain valve open
//   pump         out irrigation pump on
//   fault        out sticky fill-timeout / sensor-contradiction fault
//   cycles_done  out completed irrigation cycles, wraps at 256
// TIMER_W must hold max(FILL_TIMEOUT, CLEAN_CYCLES).
module irrigation_cycle_controller
   import irrigation_cycle_controller_pkg::*;
#(
   parameter int FILL_TIMEOUT    = 64,
   parameter int CLEAN_CYCLES    = 8,
   parameter int TIMER_W         = 8,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic                clk,
   input  logic                init,
   input  logic                start_btn,
   input  logic                level_full,
   input  logic                level_empty,
   input  logic                pesticide_on,
   output logic [1:0]          state,
   output logic                valve_in,
   output logic                valve_out,
   output logic                pump,
   output logic                fault,
   output logic [CYCLES_W-1:0] cycles_done
);

   cycle_state_t        state_q, state_d;
   logic [TIMER_W-1:0]  timer_q, timer_d;
   logic [CYCLES_W-1:0] cycles_q, cycles_d;
   logic                fault_q, fault_d;
   logic                pest_q, pest_d;
   logic                start_pulse;
   actuator_t           act;

   debouncer #(
      .STABLE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debouncer (
      .clk  (clk),
      .init (init),
      .btn  (start_btn),
      .pulse(start_pulse)
   );

   always_ff @(posedge clk) begin
      if (init) begin
         state_q  <= ST_IDLE;
         timer_q  <= '0;
         cycles_q <= '0;
         fault_q  <= 1'b0;
         pest_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         cycles_q <= cycles_d;
         fault_q  <= fault_d;
         pest_q   <= pest_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cycles_d = cycles_q;
      fault_d  = fault_q;
      // Pesticide seen on the exit edge of IRRIGATE still forces a clean,
      // so the IRRIGATE branch tests the updated flag, not the register.
      pest_d   = pest_q | (pesticide_on & (state_q == ST_FILL || state_q == ST_IRRIG));

      case (state_q)
         ST_IDLE: begin
            if (start_pulse) begin
               state_d = ST_FILL;
               fault_d = 1'b0;
            end
         end
         ST_FILL: begin
            // A full tank wins over a timeout on the same edge.
            if (level_full) begin
               if (level_empty) begin
                  state_d = ST_IDLE;
                  fault_d = 1'b1;
               end else begin
                  state_d = ST_IRRIG;
               end
            end else if (timer_q == TIMER_W'(FILL_TIMEOUT - 1)) begin
               state_d = ST_IDLE;
               fault_d = 1'b1;
            end
         end
         ST_IRRIG: begin
            if (level_empty) begin
               cycles_d = cycles_q + 1'b1;
               state_d  = pest_d ? ST_CLEAN : ST_IDLE;
            end
         end
         ST_CLEAN: begin
            if (timer_q == TIMER_W'(CLEAN_CYCLES - 1)) begin
               state_d = ST_IDLE;
               pest_d  = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Timer counts cycles spent in the current state; idle holds it at 0.
      if (state_d != state_q || state_q == ST_IDLE) begin
         timer_d = '0;
      end else begin
         timer_d = timer_q + 1'b1;
      end
   end

   always_comb begin
      act         = actuator_decode(state_q);
      state       = state_q;
      valve_in    = act.valve_in;
      valve_out   = act.valve_out;
      pump        = act.pump;
      fault       = fault_q;
      cycles_done = cycles_q;
   end

endmodule
